// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between the CPU port (C) and
// the DMA/debug loader port (D). Each port uses a request/acknowledge
// handshake. Memory strobes and the returned read data are registered.
module dmem_arbiter #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [AW-1:0]    c_addr,
  input  logic [DW-1:0]    c_wdata,
  output logic             c_ack,
  output logic             c_err,
  output logic [DW-1:0]    c_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  output logic             d_ack,
  output logic             d_err,
  output logic [DW-1:0]    d_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             gnt_id,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               gnt_id_q, gnt_id_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic               c_ack_q, c_ack_d;
  logic               c_err_q, c_err_d;
  logic [DW-1:0]      c_rdata_q, c_rdata_d;
  logic               d_ack_q, d_ack_d;
  logic               d_err_q, d_err_d;
  logic [DW-1:0]      d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]   cnt_c_q, cnt_c_d;
  logic [CNT_W-1:0]   cnt_d_q, cnt_d_d;

  logic               sel;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic               sel_aligned;
  logic               misaligned;
  logic [DW-1:0]      resp_rdata;

  // Arbitration, memory strobes, response generation and counters
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    c_ack_d      = 1'b0;
    c_err_d      = 1'b0;
    c_rdata_d    = '0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = '0;
    cnt_c_d      = cnt_c_q;
    cnt_d_d      = cnt_d_q;

    // On a tie the port that did not win last time is picked
    sel         = (c_req && d_req) ? ~last_grant_q : ~c_req;
    sel_we      = sel ? d_we    : c_we;
    sel_addr    = sel ? d_addr  : c_addr;
    sel_wdata   = sel ? d_wdata : c_wdata;
    sel_aligned = (sel_addr[1:0] == 2'b00);

    misaligned  = (addr_q[1:0] != 2'b00);
    resp_rdata  = (!we_q && !misaligned) ? mem_rdata : '0;

    unique case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          gnt_id_d     = sel;
          last_grant_d = sel;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          // Strobes are registered, so they are set up here to be high in ACCESS
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
          mem_read_d   = sel_aligned && !sel_we;
          mem_write_d  = sel_aligned && sel_we;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (gnt_id_q) begin
          d_ack_d   = 1'b1;
          d_err_d   = misaligned;
          d_rdata_d = resp_rdata;
          if (!misaligned && (cnt_d_q != '1)) cnt_d_d = cnt_d_q + CNT_W'(1);
        end else begin
          c_ack_d   = 1'b1;
          c_err_d   = misaligned;
          c_rdata_d = resp_rdata;
          if (!misaligned && (cnt_c_q != '1)) cnt_c_d = cnt_c_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      c_ack_q      <= 1'b0;
      c_err_q      <= 1'b0;
      c_rdata_q    <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      cnt_c_q      <= '0;
      cnt_d_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      c_ack_q      <= c_ack_d;
      c_err_q      <= c_err_d;
      c_rdata_q    <= c_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      cnt_c_q      <= cnt_c_d;
      cnt_d_q      <= cnt_d_d;
    end
  end

  assign c_ack     = c_ack_q;
  assign c_err     = c_err_q;
  assign c_rdata   = c_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_id_q;
  assign cnt_c     = cnt_c_q;
  assign cnt_d     = cnt_d_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, c_err, d_ack, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic        busy, gnt_id;
  logic [15:0] cnt_c, cnt_d;

  // Second instance with 2-bit counters for the saturation case
  logic        s_c_ack, s_c_err, s_d_ack, s_d_err;
  logic [31:0] s_c_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
  logic        s_mem_read, s_mem_write, s_busy, s_gnt_id;
  logic [1:0]  s_cnt_c, s_cnt_d;
  logic [31:0] s_mem_rdata;

  logic [31:0] mem [0:63];
  logic        preload;

  int checks;
  int failures;

  logic [11:0] exp_ca, exp_da, exp_g;

  dmem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .gnt_id(gnt_id), .cnt_c(cnt_c), .cnt_d(cnt_d)
  );

  dmem_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(s_c_ack), .c_err(s_c_err), .c_rdata(s_c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(s_d_ack), .d_err(s_d_err), .d_rdata(s_d_rdata),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .mem_rdata(s_mem_rdata),
    .busy(s_busy), .gnt_id(s_gnt_id), .cnt_c(s_cnt_c), .cnt_d(s_cnt_d)
  );

  assign s_mem_rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: asynchronous read, write on the clock edge
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on port C (port=0) or D (port=1)
  task automatic do_xact(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
    tick();
    check("access_mem_read",  {31'd0, mem_read},  {31'd0, !we && !exp_err});
    check("access_mem_write", {31'd0, mem_write}, {31'd0, we && !exp_err});
    check("access_mem_addr",  mem_addr, addr);
    check("access_busy",      {31'd0, busy}, 32'd1);
    tick();
    check("resp_c_ack", {31'd0, c_ack}, {31'd0, !port});
    check("resp_d_ack", {31'd0, d_ack}, {31'd0, port});
    check("resp_err",   {31'd0, port ? d_err : c_err}, {31'd0, exp_err});
    check("resp_rdata", port ? d_rdata : c_rdata, exp_rdata);
    check("resp_gnt_id", {31'd0, gnt_id}, {31'd0, port});
    check("resp_strobes_low", {30'd0, mem_read, mem_write}, 32'd0);
    if (port) d_req = 1'b0; else c_req = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_acks", {30'd0, c_ack, d_ack}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; preload = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    preload = 1'b0;
    tick();

    // Reset state
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_acks",   {30'd0, c_ack, d_ack}, 32'd0);
    check("rst_errs",   {30'd0, c_err, d_err}, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_c_rdata", c_rdata, 32'd0);
    check("rst_cnt_c", {16'd0, cnt_c}, 32'd0);
    check("rst_cnt_d", {16'd0, cnt_d}, 32'd0);
    rst = 1'b1;

    // C read at 0x10 returns preloaded word 4
    do_xact(1'b0, 1'b0, 32'h10, 32'h0, 32'd4, 1'b0);
    check("c_read_cnt_c", {16'd0, cnt_c}, 32'd1);

    // D write then read back
    do_xact(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0);
    check("d_write_mem", mem[8], 32'hDEADBEEF);
    do_xact(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0);
    check("d_cnt_d", {16'd0, cnt_d}, 32'd2);

    // Misaligned C read: no strobes, error response, counter unchanged
    do_xact(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    check("misaligned_cnt_c", {16'd0, cnt_c}, 32'd1);

    // Continuous contention from reset: grants alternate C, D, C, D
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    tick();
    rst = 1'b1;
    exp_ca = 12'b0000_1000_0010;
    exp_da = 12'b0100_0001_0000;
    exp_g  = 12'b1110_0011_1000;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("cont_c_ack",  {31'd0, c_ack},  {31'd0, exp_ca[i]});
      check("cont_d_ack",  {31'd0, d_ack},  {31'd0, exp_da[i]});
      check("cont_gnt_id", {31'd0, gnt_id}, {31'd0, exp_g[i]});
    end
    c_req = 1'b0; d_req = 1'b0;
    check("cont_cnt_c", {16'd0, cnt_c}, 32'd2);
    check("cont_cnt_d", {16'd0, cnt_d}, 32'd2);
    tick();

    // Reset during ACCESS of a C write: write lands, no ack, counters cleared
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'h55AA1234;
    tick();
    check("rstmid_mem_write", {31'd0, mem_write}, 32'd1);
    rst = 1'b0;
    tick();
    check("rstmid_mem",     mem[12], 32'h55AA1234);
    check("rstmid_c_ack",   {31'd0, c_ack}, 32'd0);
    check("rstmid_busy",    {31'd0, busy}, 32'd0);
    check("rstmid_cnt",     {cnt_c, cnt_d}, 32'd0);
    check("rstmid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    c_req = 1'b0;
    rst = 1'b1;
    tick();
    check("rstmid_after_c_ack", {31'd0, c_ack}, 32'd0);
    check("rstmid_after_busy",  {31'd0, busy}, 32'd0);

    // Saturation: five C reads, 2-bit counter stops at 3
    for (int i = 0; i < 5; i++) begin
      do_xact(1'b0, 1'b0, 32'(i * 4), 32'h0, 32'(i), 1'b0);
    end
    check("sat_main_cnt_c", {16'd0, cnt_c}, 32'd5);
    check("sat_cnt_c", {30'd0, s_cnt_c}, 32'd3);
    check("sat_cnt_d", {30'd0, s_cnt_d}, 32'd0);
    check("sat_idle",  {29'd0, s_busy, s_c_ack, s_d_ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
